// File: rtl/xedgcol_dispatch.sv
// Dispatch unit for the Xedgcol collision accelerator: banked edge-coordinate
// register file plus an ap_ctrl_hs start/done sequencer with a one-deep launch queue.
module xedgcol_dispatch #(
    parameter int DATA_WIDTH     = 32,
    parameter int IMM_SHIFT      = 6,
    parameter int NUM_BANKS      = 2,
    parameter int RESULT_WIDTH   = 64,
    parameter int TIMEOUT_CYCLES = 1023,
    localparam int BANK_W        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_ena,
    input  logic [BANK_W-1:0]         wr_bank,
    input  logic [2:0]                wr_addr,
    input  logic [DATA_WIDTH-IMM_SHIFT-1:0] wr_imm,
    output logic                      wr_ack,
    input  logic                      start,
    input  logic [BANK_W-1:0]         start_bank,
    output logic                      busy,
    output logic                      done,
    output logic [RESULT_WIDTH-1:0]   result,
    output logic                      timeout,
    output logic                      overflow,
    output logic                      acc_start,
    input  logic                      acc_done,
    input  logic [RESULT_WIDTH-1:0]   acc_return,
    output logic [6*DATA_WIDTH-1:0]   acc_edges
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BANK_W-1:0]       act_q, act_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [BANK_W-1:0]       pend_bank_q, pend_bank_d;
    logic [RESULT_WIDTH-1:0] result_q, result_d;
    logic                    timeout_q, timeout_d;
    logic                    overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_BANKS][6];
    logic [DATA_WIDTH-1:0]   wdata;

    assign wdata = DATA_WIDTH'(wr_imm) << IMM_SHIFT;

    // The active bank is frozen for the whole run so the accelerator sees stable inputs.
    assign wr_ack = wr_ena && (wr_addr <= 3'd5) && (32'(wr_bank) < NUM_BANKS)
                    && !((state_q == S_RUN) && (wr_bank == act_q));

    assign busy      = (state_q != S_IDLE) || pend_vld_q;
    assign done      = (state_q == S_DONE);
    assign acc_start = (state_q == S_RUN);
    assign result    = result_q;
    assign timeout   = timeout_q;
    assign overflow  = overflow_q;

    always_comb begin
        acc_edges = '0;
        for (int k = 0; k < 6; k++) begin
            acc_edges[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[act_q][k];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_d       = act_q;
        pend_vld_d  = pend_vld_q;
        pend_bank_d = pend_bank_q;
        result_d    = result_q;
        timeout_d   = timeout_q;
        overflow_d  = overflow_q;
        case (state_q)
            S_IDLE: begin
                // A queued launch wins; a start arriving alongside it refills the freed slot.
                if (pend_vld_q) begin
                    state_d     = S_RUN;
                    cnt_d       = '0;
                    act_d       = pend_bank_q;
                    pend_vld_d  = start;
                    pend_bank_d = start_bank;
                end else if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    act_d   = start_bank;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (acc_done) begin
                    result_d = acc_return;
                    state_d  = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (start && (state_q != S_IDLE)) begin
            if (!pend_vld_q) begin
                pend_vld_d  = 1'b1;
                pend_bank_d = start_bank;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            act_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_bank_q <= '0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_q       <= act_d;
            pend_vld_q  <= pend_vld_d;
            pend_bank_q <= pend_bank_d;
            result_q    <= result_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int k = 0; k < 6; k++) begin
                if (rst) begin
                    regs_q[b][k] <= '0;
                end else if (wr_ack && (32'(wr_bank) == b) && (32'(wr_addr) == k)) begin
                    regs_q[b][k] <= wdata;
                end
            end
        end
    end

endmodule
